// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
//   Shared RV32I core package. It holds the decoded-instruction enums that
//   decode and execute agree on, and the payload carried by the ID/EX
//   pipeline register.
//
//   Contents:
//     ADDR_W, DATA_W, REG_ADDR_W : core-wide width constants
//     rv32i_base_instr           : decoded base-ISA opcode
//     rv32i_base_instr_type      : instruction encoding format (R/I/S/B/U/J)
//     id_ex_payload_t            : one decoded instruction as seen by execute
//     id_ex_payload_width()      : payload width in bits
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    // Decoded base-ISA opcode. The value 0 (LUI) is also the register reset
    // value, which is harmless because valid bits qualify the payload.
    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK
    } rv32i_base_instr;

    typedef enum logic [2:0] {
        R_TYPE,
        I_TYPE,
        S_TYPE,
        B_TYPE,
        U_TYPE,
        J_TYPE
    } rv32i_base_instr_type;

    // Full decoded instruction handed from decode to execute.
    typedef struct packed {
        logic [ADDR_W-1:0]     pc;
        rv32i_base_instr       opcode;
        rv32i_base_instr_type  instr_type;
        logic [DATA_W-1:0]     rs1_data;
        logic [DATA_W-1:0]     rs2_data;
        logic [DATA_W-1:0]     imm_value;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
    } id_ex_payload_t;

    function automatic int id_ex_payload_width();
        return $bits(id_ex_payload_t);
    endfunction

endpackage : rv32i_pkg

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
//   Generic two-entry valid/ready skid buffer over an opaque payload.
//   The main entry drives the output; the skid entry catches the one extra
//   transfer that decode can push in the cycle execute stalls. Because the
//   upstream ready only needs to know whether the skid entry is occupied, it
//   is produced straight from a flop: no combinational path from out_ready_i
//   back to in_ready_o. Intended for reuse at ID/EX, EX/MEM and MEM/WB.
//
//   Ports:
//     clk_i        : clock, all state changes on the rising edge
//     rst_ni       : synchronous active-low reset (clears valids and data)
//     flush_i      : empty both entries; an accept in the same cycle is lost
//     in_valid_i   : upstream offers in_data_i
//     in_ready_o   : registered, high when the skid entry is empty
//     in_data_i    : incoming payload
//     out_valid_o  : main entry holds a valid payload
//     out_ready_i  : downstream consumes the main entry
//     out_data_o   : main entry payload
// ---------------------------------------------------------------------------
module pipe_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q,   in_ready_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;

    logic accept;
    logic consume;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;

        accept  = in_valid_i && in_ready_q;
        consume = main_valid_q && out_ready_i;

        // The skid entry is only ever occupied while main is occupied, so an
        // empty main implies an empty skid.
        if (!main_valid_q) begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data_i;
            end
        end else if (consume) begin
            if (skid_valid_q) begin
                // in_ready_q is low here, so no accept can collide with this.
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d  = in_data_i;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Main is stalled: park the new payload, keep main untouched.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end

        // Flush only clears the valids; the data registers may keep stale
        // contents since nothing downstream looks at them without a valid.
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

endmodule : pipe_skid_buf

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//   Decode-to-execute pipeline register of the RV32I core. Packs the decoded
//   instruction fields into one payload word, passes it through a two-entry
//   skid buffer, and unpacks the buffered payload for the ALU operand-select
//   logic. in_ready_o is a flop output; flush_i drops everything held plus
//   any instruction offered in the same cycle (branch/jump redirect).
//
//   Ports:
//     clk_i, rst_ni, flush_i        : clock, sync active-low reset, flush
//     in_valid_i / in_ready_o       : decode-side handshake
//     in_pc_i .. in_rd_addr_i       : decoded instruction fields
//     out_valid_o / out_ready_i     : execute-side handshake
//     out_pc_o .. out_rd_addr_o     : registered instruction fields
// ---------------------------------------------------------------------------
module id_ex_pipe_reg
    import rv32i_pkg::*;
#(
    parameter int ADDR_WIDTH     = rv32i_pkg::ADDR_W,
    parameter int DATA_WIDTH     = rv32i_pkg::DATA_W,
    parameter int REG_ADDR_WIDTH = rv32i_pkg::REG_ADDR_W
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,

    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [ADDR_WIDTH-1:0]     in_pc_i,
    input  rv32i_base_instr           in_opcode_i,
    input  rv32i_base_instr_type      in_instr_type_i,
    input  logic [DATA_WIDTH-1:0]     in_rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     in_rs2_data_i,
    input  logic [DATA_WIDTH-1:0]     in_imm_value_i,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr_i,

    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [ADDR_WIDTH-1:0]     out_pc_o,
    output rv32i_base_instr           out_opcode_o,
    output rv32i_base_instr_type      out_instr_type_o,
    output logic [DATA_WIDTH-1:0]     out_rs1_data_o,
    output logic [DATA_WIDTH-1:0]     out_rs2_data_o,
    output logic [DATA_WIDTH-1:0]     out_imm_value_o,
    output logic [REG_ADDR_WIDTH-1:0] out_rs1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] out_rs2_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] out_rd_addr_o
);

    localparam int PAYLOAD_W = $bits(id_ex_payload_t);

    id_ex_payload_t in_payload;
    id_ex_payload_t out_payload;

    always_comb begin
        in_payload            = '0;
        in_payload.pc         = in_pc_i;
        in_payload.opcode     = in_opcode_i;
        in_payload.instr_type = in_instr_type_i;
        in_payload.rs1_data   = in_rs1_data_i;
        in_payload.rs2_data   = in_rs2_data_i;
        in_payload.imm_value  = in_imm_value_i;
        in_payload.rs1_addr   = in_rs1_addr_i;
        in_payload.rs2_addr   = in_rs2_addr_i;
        in_payload.rd_addr    = in_rd_addr_i;
    end

    pipe_skid_buf #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_payload),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_payload)
    );

    assign out_pc_o         = out_payload.pc;
    assign out_opcode_o     = out_payload.opcode;
    assign out_instr_type_o = out_payload.instr_type;
    assign out_rs1_data_o   = out_payload.rs1_data;
    assign out_rs2_data_o   = out_payload.rs2_data;
    assign out_imm_value_o  = out_payload.imm_value;
    assign out_rs1_addr_o   = out_payload.rs1_addr;
    assign out_rs2_addr_o   = out_payload.rs2_addr;
    assign out_rd_addr_o    = out_payload.rd_addr;

endmodule : id_ex_pipe_reg

// File: tb/tb_id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_reg
//   Directed vector table for reset, streaming, backpressure, flush and
//   reset/flush overlap, followed by a randomised handshake sequence checked
//   against a queue model of the two-entry buffer.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_reg;
    import rv32i_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [31:0]           in_pc = '0;
    rv32i_base_instr       in_opcode = LUI;
    rv32i_base_instr_type  in_type = R_TYPE;
    logic [31:0]           in_rs1_data = '0;
    logic [31:0]           in_rs2_data = '0;
    logic [31:0]           in_imm = '0;
    logic [4:0]            in_rs1_addr = '0;
    logic [4:0]            in_rs2_addr = '0;
    logic [4:0]            in_rd_addr = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [31:0]           out_pc;
    rv32i_base_instr       out_opcode;
    rv32i_base_instr_type  out_type;
    logic [31:0]           out_rs1_data;
    logic [31:0]           out_rs2_data;
    logic [31:0]           out_imm;
    logic [4:0]            out_rs1_addr;
    logic [4:0]            out_rs2_addr;
    logic [4:0]            out_rd_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_pc_i          (in_pc),
        .in_opcode_i      (in_opcode),
        .in_instr_type_i  (in_type),
        .in_rs1_data_i    (in_rs1_data),
        .in_rs2_data_i    (in_rs2_data),
        .in_imm_value_i   (in_imm),
        .in_rs1_addr_i    (in_rs1_addr),
        .in_rs2_addr_i    (in_rs2_addr),
        .in_rd_addr_i     (in_rd_addr),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_pc_o         (out_pc),
        .out_opcode_o     (out_opcode),
        .out_instr_type_o (out_type),
        .out_rs1_data_o   (out_rs1_data),
        .out_rs2_data_o   (out_rs2_data),
        .out_imm_value_o  (out_imm),
        .out_rs1_addr_o   (out_rs1_addr),
        .out_rs2_addr_o   (out_rs2_addr),
        .out_rd_addr_o    (out_rd_addr)
    );

    id_ex_payload_t out_p;
    always_comb begin
        out_p            = '0;
        out_p.pc         = out_pc;
        out_p.opcode     = out_opcode;
        out_p.instr_type = out_type;
        out_p.rs1_data   = out_rs1_data;
        out_p.rs2_data   = out_rs2_data;
        out_p.imm_value  = out_imm;
        out_p.rs1_addr   = out_rs1_addr;
        out_p.rs2_addr   = out_rs2_addr;
        out_p.rd_addr    = out_rd_addr;
    end

    // Every pc maps to a fixed, distinctive decoded instruction so the whole
    // payload can be predicted from the pc alone.
    function automatic id_ex_payload_t make_payload(input logic [31:0] pc);
        id_ex_payload_t p;
        p = '0;
        p.pc       = pc;
        p.rs1_data = pc ^ 32'hA5A5_0000;
        p.rs2_data = ~pc;
        p.rs1_addr = pc[6:2];
        p.rs2_addr = pc[11:7];
        p.rd_addr  = pc[8:4] ^ 5'h1F;
        if (pc[11:8] == 4'h1) begin
            p.opcode = ADDI; p.instr_type = I_TYPE; p.imm_value = 32'hFFFF_FFFC;
        end else begin
            case (pc[3:2])
                2'd0: begin p.opcode = ADDI; p.instr_type = I_TYPE; p.imm_value = 32'hFFFF_FFFC; end
                2'd1: begin p.opcode = ADD;  p.instr_type = R_TYPE; p.imm_value = 32'h0; end
                2'd2: begin p.opcode = SW;   p.instr_type = S_TYPE; p.imm_value = {20'h0, pc[11:0]}; end
                default: begin p.opcode = BEQ; p.instr_type = B_TYPE; p.imm_value = 32'hFFFF_FFF0; end
            endcase
        end
        return p;
    endfunction

    task automatic drive_payload(input logic [31:0] pc);
        id_ex_payload_t p;
        p = make_payload(pc);
        in_pc       = p.pc;
        in_opcode   = p.opcode;
        in_type     = p.instr_type;
        in_rs1_data = p.rs1_data;
        in_rs2_data = p.rs2_data;
        in_imm      = p.imm_value;
        in_rs1_addr = p.rs1_addr;
        in_rs2_addr = p.rs2_addr;
        in_rd_addr  = p.rd_addr;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Directed vectors: inputs held during one cycle, expectations sampled
    // 1 time unit after the following rising edge.
    // mode 0: handshake only, 1: also full payload for exp_pc, 2: all-zero payload
    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        in_valid;
        logic [31:0] pc;
        logic        out_ready;
        logic        exp_valid;
        logic        exp_ready;
        logic [31:0] exp_pc;
        int          mode;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                                input logic ordy, input logic ev, input logic er,
                                input logic [31:0] epc, input int mode);
        vec_t v;
        v.rst_n = r; v.flush = f; v.in_valid = iv; v.pc = pc; v.out_ready = ordy;
        v.exp_valid = ev; v.exp_ready = er; v.exp_pc = epc; v.mode = mode;
        return v;
    endfunction

    logic [31:0] model_q[$];

    initial begin
        //              rst f  iv pc          ordy ev er exp_pc      mode
        // reset held two cycles with an offer present
        vecs[0]  = mk(0, 0, 1, 32'h100, 0,  0, 1, 32'h0,   2);
        vecs[1]  = mk(0, 0, 1, 32'h100, 0,  0, 1, 32'h0,   2);
        // release: first accept shows next cycle, then streaming
        vecs[2]  = mk(1, 0, 1, 32'h100, 1,  1, 1, 32'h100, 1);
        vecs[3]  = mk(1, 0, 1, 32'h104, 1,  1, 1, 32'h104, 1);
        vecs[4]  = mk(1, 0, 1, 32'h108, 1,  1, 1, 32'h108, 1);
        vecs[5]  = mk(1, 0, 0, 32'h0,   1,  0, 1, 32'h0,   0);
        // backpressure: 0x200 in main, 0x204 in skid, 0x208 refused
        vecs[6]  = mk(1, 0, 1, 32'h200, 0,  1, 1, 32'h200, 1);
        vecs[7]  = mk(1, 0, 1, 32'h204, 0,  1, 0, 32'h200, 1);
        vecs[8]  = mk(1, 0, 1, 32'h208, 0,  1, 0, 32'h200, 1);
        vecs[9]  = mk(1, 0, 1, 32'h208, 1,  1, 1, 32'h204, 1);
        vecs[10] = mk(1, 0, 1, 32'h208, 1,  1, 1, 32'h208, 1);
        vecs[11] = mk(1, 0, 0, 32'h0,   1,  0, 1, 32'h0,   0);
        // flush with both entries full and 0x300 offered
        vecs[12] = mk(1, 0, 1, 32'h2F0, 0,  1, 1, 32'h2F0, 1);
        vecs[13] = mk(1, 0, 1, 32'h2F4, 0,  1, 0, 32'h2F0, 1);
        vecs[14] = mk(1, 1, 1, 32'h300, 0,  0, 1, 32'h0,   0);
        vecs[15] = mk(1, 0, 0, 32'h0,   1,  0, 1, 32'h0,   0);
        // flush while an accept would happen: accept dropped
        vecs[16] = mk(1, 0, 1, 32'h310, 0,  1, 1, 32'h310, 1);
        vecs[17] = mk(1, 1, 1, 32'h314, 1,  0, 1, 32'h0,   0);
        vecs[18] = mk(1, 0, 0, 32'h0,   1,  0, 1, 32'h0,   0);
        // simultaneous accept and consume, main full, skid empty
        vecs[19] = mk(1, 0, 1, 32'h400, 0,  1, 1, 32'h400, 1);
        vecs[20] = mk(1, 0, 1, 32'h404, 1,  1, 1, 32'h404, 1);
        vecs[21] = mk(1, 0, 0, 32'h0,   0,  1, 1, 32'h404, 1);
        // fill skid, then reset and flush together
        vecs[22] = mk(1, 0, 1, 32'h500, 0,  1, 0, 32'h404, 1);
        vecs[23] = mk(0, 1, 1, 32'h504, 1,  0, 1, 32'h0,   2);
        vecs[24] = mk(1, 0, 0, 32'h0,   0,  0, 1, 32'h0,   2);

        #2;
        for (int i = 0; i < NVEC; i++) begin
            rst_n     = vecs[i].rst_n;
            flush     = vecs[i].flush;
            in_valid  = vecs[i].in_valid;
            out_ready = vecs[i].out_ready;
            drive_payload(vecs[i].pc);
            @(posedge clk);
            #1;
            $display("vec %0d: rst_n=%0b flush=%0b in_valid=%0b pc=%0h out_ready=%0b -> out_valid=%0b in_ready=%0b out_pc=%0h",
                     i, vecs[i].rst_n, vecs[i].flush, vecs[i].in_valid, vecs[i].pc, vecs[i].out_ready,
                     out_valid, in_ready, out_pc);
            check($sformatf("vec%0d out_valid", i), 256'(out_valid), 256'(vecs[i].exp_valid));
            check($sformatf("vec%0d in_ready", i), 256'(in_ready), 256'(vecs[i].exp_ready));
            if (vecs[i].mode == 1)
                check($sformatf("vec%0d payload", i), 256'(out_p), 256'(make_payload(vecs[i].exp_pc)));
            else if (vecs[i].mode == 2)
                check($sformatf("vec%0d zero payload", i), 256'(out_p), 256'(0));
        end

        // Randomised handshake with occasional flush, against a queue model.
        // The buffer is empty here (just out of reset).
        begin
            logic [31:0] next_pc;
            logic        acc;
            logic        con;
            next_pc = 32'h1000;
            for (int c = 0; c < 200; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                flush     = ($urandom_range(0, 24) == 0);
                drive_payload(next_pc);
                acc = in_valid && (model_q.size() < 2);
                con = out_ready && (model_q.size() > 0);
                @(posedge clk);
                #1;
                if (con) void'(model_q.pop_front());
                if (flush) model_q.delete();
                else if (acc) begin
                    model_q.push_back(next_pc);
                    next_pc = next_pc + 32'd4;
                end
                $display("cyc %0d: in_valid=%0b out_ready=%0b flush=%0b -> out_valid=%0b in_ready=%0b out_pc=%0h occ=%0d",
                         c, in_valid, out_ready, flush, out_valid, in_ready, out_pc, model_q.size());
                check($sformatf("rnd%0d out_valid", c), 256'(out_valid), 256'(model_q.size() > 0));
                check($sformatf("rnd%0d in_ready", c), 256'(in_ready), 256'(model_q.size() < 2));
                if (model_q.size() > 0)
                    check($sformatf("rnd%0d payload", c), 256'(out_p), 256'(make_payload(model_q[0])));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_id_ex_pipe_reg
